// File: rtl/if_stage.sv
// Instruction-fetch stage for the SCPU datapath.
// Holds the PC, fetches over a req/ack handshake, presents the registered
// instruction to the decoder and commits the next PC on retire.
// Optional feature macro: IF_ALIGN_CHECK_EN (adds addr_err and a terminal
// ERROR state on a misaligned jr target).
module if_stage #(
    parameter logic [31:0] RESET_PC      = 32'h0000_0000,
    parameter int unsigned FETCH_TIMEOUT = 16
) (
    input  logic        clk,
    input  logic        rstn,
    output logic        imem_req,
    output logic [31:0] imem_addr,
    input  logic        imem_ack,
    input  logic [31:0] imem_rdata,
    output logic [31:0] instr,
    output logic        instr_valid,
    output logic [31:0] pc,
    output logic [31:0] pc_plus4,
    input  logic [1:0]  npc_op,
    input  logic [31:0] rs_data,
    input  logic        retire,
`ifdef IF_ALIGN_CHECK_EN
    output logic        addr_err,
`endif
    output logic        fetch_timeout
);

    localparam int unsigned    CNT_W   = $clog2(FETCH_TIMEOUT);
    localparam logic [CNT_W-1:0] CNT_MAX = CNT_W'(FETCH_TIMEOUT - 1);

    localparam logic [1:0] OP_PLUS4  = 2'b00;
    localparam logic [1:0] OP_BRANCH = 2'b01;
    localparam logic [1:0] OP_JUMP   = 2'b10;
    localparam logic [1:0] OP_JR     = 2'b11;

    typedef enum logic [1:0] {
        S_IDLE,
        S_FETCH,
        S_VALID,
        S_ERROR
    } state_t;

    state_t           state, state_n;
    logic [CNT_W-1:0] cnt, cnt_n;
    logic [31:0]      pc_n, pc_plus4_n, instr_n, npc, jr_target;
    logic             req_n, valid_n, timeout_n;
`ifdef IF_ALIGN_CHECK_EN
    logic             addr_err_n;
`endif

    // The fetch address is the registered pc, so it is stable while requesting.
    assign imem_addr = pc;

    // jr target keeps rs[31:2]; the low bits are masked to word alignment.
    assign jr_target = rs_data & 32'hFFFF_FFFC;

    // Next-PC selection from the decoder's already Zero-qualified npc_op.
    always_comb begin
        npc = pc_plus4;
        case (npc_op)
            OP_PLUS4:  npc = pc_plus4;
            OP_BRANCH: npc = pc_plus4 + {{14{instr[15]}}, instr[15:0], 2'b00};
            OP_JUMP:   npc = {pc_plus4[31:28], instr[25:0], 2'b00};
            OP_JR:     npc = jr_target;
            default:   npc = pc_plus4;
        endcase
    end

    // Next-state and next-register values for the fetch FSM.
    always_comb begin
        state_n    = state;
        cnt_n      = cnt;
        pc_n       = pc;
        pc_plus4_n = pc_plus4;
        instr_n    = instr;
        valid_n    = instr_valid;
        req_n      = 1'b0;
        timeout_n  = fetch_timeout;
`ifdef IF_ALIGN_CHECK_EN
        addr_err_n = addr_err;
`endif
        case (state)
            S_IDLE: begin
                state_n = S_FETCH;
                cnt_n   = '0;
                req_n   = 1'b1;
            end
            S_FETCH: begin
                if (!imem_req) begin
                    // Dropped-request cycle: ack ignored, re-issue same address.
                    req_n = 1'b1;
                end else if (imem_ack) begin
                    // An ack coinciding with expiry wins over the timeout.
                    instr_n = imem_rdata;
                    valid_n = 1'b1;
                    cnt_n   = '0;
                    state_n = S_VALID;
                end else if (cnt == CNT_MAX) begin
                    cnt_n     = '0;
                    timeout_n = 1'b1;
                end else begin
                    cnt_n = cnt + CNT_W'(1);
                    req_n = 1'b1;
                end
            end
            S_VALID: begin
                if (retire) begin
`ifdef IF_ALIGN_CHECK_EN
                    if (npc_op == OP_JR && rs_data[1:0] != 2'b00) begin
                        addr_err_n = 1'b1;
                        valid_n    = 1'b0;
                        state_n    = S_ERROR;
                    end else begin
                        pc_n       = npc;
                        pc_plus4_n = npc + 32'd4;
                        valid_n    = 1'b0;
                        req_n      = 1'b1;
                        state_n    = S_FETCH;
                    end
`else
                    pc_n       = npc;
                    pc_plus4_n = npc + 32'd4;
                    valid_n    = 1'b0;
                    req_n      = 1'b1;
                    state_n    = S_FETCH;
`endif
                end
            end
            S_ERROR: begin
                valid_n = 1'b0;
            end
            default: begin
                state_n = S_IDLE;
            end
        endcase
    end

    // State and datapath registers.
    always_ff @(posedge clk or negedge rstn) begin
        if (!rstn) begin
            state         <= S_IDLE;
            cnt           <= '0;
            pc            <= RESET_PC;
            pc_plus4      <= RESET_PC + 32'd4;
            instr         <= '0;
            instr_valid   <= 1'b0;
            imem_req      <= 1'b0;
            fetch_timeout <= 1'b0;
`ifdef IF_ALIGN_CHECK_EN
            addr_err      <= 1'b0;
`endif
        end else begin
            state         <= state_n;
            cnt           <= cnt_n;
            pc            <= pc_n;
            pc_plus4      <= pc_plus4_n;
            instr         <= instr_n;
            instr_valid   <= valid_n;
            imem_req      <= req_n;
            fetch_timeout <= timeout_n;
`ifdef IF_ALIGN_CHECK_EN
            addr_err      <= addr_err_n;
`endif
        end
    end

endmodule

// File: tb/tb_if_stage.sv
// Testbench for if_stage: table of fetch/retire transactions plus
// hand-written sequences for timeout, reset and alignment corner cases.
module tb_if_stage;

    logic        clk = 1'b0;
    logic        rstn;
    logic        imem_req;
    logic [31:0] imem_addr;
    logic        imem_ack;
    logic [31:0] imem_rdata;
    logic [31:0] instr;
    logic        instr_valid;
    logic [31:0] pc;
    logic [31:0] pc_plus4;
    logic [1:0]  npc_op;
    logic [31:0] rs_data;
    logic        retire;
    logic        fetch_timeout;
`ifdef IF_ALIGN_CHECK_EN
    logic        addr_err;
`endif

    int n_chk  = 0;
    int n_fail = 0;

    if_stage #(.RESET_PC(32'h0000_0000), .FETCH_TIMEOUT(16)) dut (
        .clk          (clk),
        .rstn         (rstn),
        .imem_req     (imem_req),
        .imem_addr    (imem_addr),
        .imem_ack     (imem_ack),
        .imem_rdata   (imem_rdata),
        .instr        (instr),
        .instr_valid  (instr_valid),
        .pc           (pc),
        .pc_plus4     (pc_plus4),
        .npc_op       (npc_op),
        .rs_data      (rs_data),
        .retire       (retire),
`ifdef IF_ALIGN_CHECK_EN
        .addr_err     (addr_err),
`endif
        .fetch_timeout(fetch_timeout)
    );

    always #5 clk = ~clk;

    typedef struct {
        int          ack_dly;
        logic [31:0] exp_addr;
        logic [31:0] rdata;
        logic [1:0]  op;
        logic [31:0] rs;
        int          ret_dly;
        logic [31:0] exp_npc;
    } vec_t;

    vec_t vecs[11];

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_chk++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got %h expected %h", name, act, exp);
        end
    endtask

    task automatic chk1(input string name, input logic act, input logic exp);
        n_chk++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got %b expected %b", name, act, exp);
        end
    endtask

    task automatic wait_req();
        int n = 0;
        while (imem_req !== 1'b1 && n < 50) begin
            tick();
            n++;
        end
        chk1("req_wait", imem_req, 1'b1);
    endtask

    initial begin
        vecs[0]  = '{0, 32'h0000_0000, 32'h2008_0005, 2'b00, 32'h0,         0, 32'h0000_0004};
        vecs[1]  = '{1, 32'h0000_0004, 32'h1000_FFFF, 2'b01, 32'h0,         1, 32'h0000_0004};
        vecs[2]  = '{0, 32'h0000_0004, 32'h0800_0C04, 2'b10, 32'h0,         0, 32'h0000_3010};
        vecs[3]  = '{2, 32'h0000_3010, 32'h0800_0C04, 2'b10, 32'h0,         2, 32'h0000_3010};
        vecs[4]  = '{0, 32'h0000_3010, 32'h0000_0008, 2'b11, 32'h0000_0040, 0, 32'h0000_0040};
        vecs[5]  = '{3, 32'h0000_0040, 32'h1000_0010, 2'b01, 32'h0,         0, 32'h0000_0084};
        vecs[6]  = '{0, 32'h0000_0084, 32'h0000_0008, 2'b11, 32'hFFFF_FFFC, 1, 32'hFFFF_FFFC};
        vecs[7]  = '{0, 32'hFFFF_FFFC, 32'h2008_0001, 2'b00, 32'h0,         0, 32'h0000_0000};
        vecs[8]  = '{1, 32'h0000_0000, 32'h1000_8000, 2'b01, 32'h0,         0, 32'hFFFE_0004};
        vecs[9]  = '{0, 32'hFFFE_0004, 32'h1000_7FFF, 2'b01, 32'h0,         0, 32'h0000_0004};
        vecs[10] = '{0, 32'h0000_0004, 32'h2008_0002, 2'b00, 32'h0,         0, 32'h0000_0008};

        rstn = 1'b0; imem_ack = 1'b0; imem_rdata = 32'h0;
        npc_op = 2'b00; rs_data = 32'h0; retire = 1'b0;
        tick(); tick();

        // Reset state
        chk1("rst_req", imem_req, 1'b0);
        chk1("rst_valid", instr_valid, 1'b0);
        chk("rst_pc", pc, 32'h0);
        chk("rst_pc_plus4", pc_plus4, 32'h4);
        chk("rst_instr", instr, 32'h0);
        chk1("rst_timeout", fetch_timeout, 1'b0);
`ifdef IF_ALIGN_CHECK_EN
        chk1("rst_addr_err", addr_err, 1'b0);
`endif
        rstn = 1'b1;

        // Table of fetch/retire transactions
        for (int i = 0; i < 11; i++) begin
            wait_req();
            chk($sformatf("v%0d_addr", i), imem_addr, vecs[i].exp_addr);
            chk($sformatf("v%0d_pc", i), pc, vecs[i].exp_addr);
            repeat (vecs[i].ack_dly) tick();
            chk1($sformatf("v%0d_req_held", i), imem_req, 1'b1);
            imem_ack = 1'b1; imem_rdata = vecs[i].rdata;
            tick();
            imem_ack = 1'b0; imem_rdata = 32'hDEAD_BEEF;
            chk1($sformatf("v%0d_valid", i), instr_valid, 1'b1);
            chk($sformatf("v%0d_instr", i), instr, vecs[i].rdata);
            chk1($sformatf("v%0d_req_low", i), imem_req, 1'b0);
            chk($sformatf("v%0d_pc_plus4", i), pc_plus4, vecs[i].exp_addr + 32'd4);
            for (int k = 0; k < vecs[i].ret_dly; k++) begin
                imem_ack = 1'b1;
                tick();
                imem_ack = 1'b0;
            end
            chk($sformatf("v%0d_instr_hold", i), instr, vecs[i].rdata);
            retire = 1'b1; npc_op = vecs[i].op; rs_data = vecs[i].rs;
            tick();
            retire = 1'b0; npc_op = 2'b00; rs_data = 32'h0;
            chk1($sformatf("v%0d_valid_clr", i), instr_valid, 1'b0);
            chk($sformatf("v%0d_npc", i), pc, vecs[i].exp_npc);
            chk1($sformatf("v%0d_refetch", i), imem_req, 1'b1);
        end

        // Ack in the expiry cycle is accepted and not counted as a timeout
        repeat (15) tick();
        chk1("exp_req_high", imem_req, 1'b1);
        imem_ack = 1'b1; imem_rdata = 32'h2008_0003;
        tick();
        imem_ack = 1'b0;
        chk1("exp_valid", instr_valid, 1'b1);
        chk("exp_instr", instr, 32'h2008_0003);
        chk1("exp_no_timeout", fetch_timeout, 1'b0);
        retire = 1'b1; npc_op = 2'b00;
        tick();
        retire = 1'b0;
        chk("exp_npc", pc, 32'h0000_000C);

        // Timeout: retire in FETCH ignored, then request drops for one cycle
        retire = 1'b1; npc_op = 2'b11; rs_data = 32'h0000_0100;
        tick();
        retire = 1'b0; npc_op = 2'b00; rs_data = 32'h0;
        chk("to_retire_ignored_pc", pc, 32'h0000_000C);
        chk1("to_retire_ignored_valid", instr_valid, 1'b0);
        repeat (14) tick();
        chk1("to_req_before", imem_req, 1'b1);
        chk1("to_flag_before", fetch_timeout, 1'b0);
        tick();
        chk1("to_req_drop", imem_req, 1'b0);
        chk1("to_flag_set", fetch_timeout, 1'b1);
        imem_ack = 1'b1; imem_rdata = 32'h1234_5678;
        tick();
        imem_ack = 1'b0;
        chk1("to_drop_ack_ignored", instr_valid, 1'b0);
        chk1("to_req_reissue", imem_req, 1'b1);
        chk("to_same_addr", imem_addr, 32'h0000_000C);
        imem_ack = 1'b1; imem_rdata = 32'h2008_0007;
        tick();
        imem_ack = 1'b0;
        chk1("to_valid", instr_valid, 1'b1);
        chk("to_instr", instr, 32'h2008_0007);
        retire = 1'b1; npc_op = 2'b00;
        tick();
        retire = 1'b0;
        chk("to_npc", pc, 32'h0000_0010);

        // Reset mid-fetch, late ack after release is ignored
        tick(); tick();
        rstn = 1'b0;
        #1;
        chk1("mr_req", imem_req, 1'b0);
        chk1("mr_valid", instr_valid, 1'b0);
        chk("mr_pc", pc, 32'h0);
        tick();
        rstn = 1'b1;
        imem_ack = 1'b1; imem_rdata = 32'h1111_1111;
        tick();
        imem_ack = 1'b0;
        chk1("mr_req_restart", imem_req, 1'b1);
        chk("mr_addr", imem_addr, 32'h0);
        chk1("mr_late_ack_ignored", instr_valid, 1'b0);
        tick();
        chk1("mr_still_invalid", instr_valid, 1'b0);
        imem_ack = 1'b1; imem_rdata = 32'h2008_0005;
        tick();
        imem_ack = 1'b0;
        chk1("mr_valid_after", instr_valid, 1'b1);
        chk("mr_instr", instr, 32'h2008_0005);

`ifdef IF_ALIGN_CHECK_EN
        // Misaligned jr target enters the terminal error state
        chk1("al_err_before", addr_err, 1'b0);
        retire = 1'b1; npc_op = 2'b11; rs_data = 32'h0000_0042;
        tick();
        retire = 1'b0; npc_op = 2'b00; rs_data = 32'h0;
        chk1("al_err", addr_err, 1'b1);
        chk1("al_valid", instr_valid, 1'b0);
        chk("al_pc", pc, 32'h0);
        for (int k = 0; k < 5; k++) begin
            imem_ack = 1'b1;
            tick();
            imem_ack = 1'b0;
            chk1($sformatf("al_no_req_%0d", k), imem_req, 1'b0);
        end
`else
        // jr target low bits are masked
        retire = 1'b1; npc_op = 2'b11; rs_data = 32'h0000_0043;
        tick();
        retire = 1'b0; npc_op = 2'b00; rs_data = 32'h0;
        chk("jr_mask_pc", pc, 32'h0000_0040);
        chk1("jr_mask_req", imem_req, 1'b1);
`endif

        $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
        $finish;
    end

endmodule
